// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshakes and a shift-add multiply
module alu_pipe #(
  parameter int WIDTH = 4,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);
  localparam int MSB   = WIDTH - 1;
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_EQ   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SHL  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SHR  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(11);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, acc_next;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum_ext, dif_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             accept, retire, is_mul, mul_last;

  assign in_ready = ~rst & (state_q == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign retire   = out_valid & out_ready;
  assign is_mul   = (op == OP_MUL);
  assign mul_last = (state_q == MUL) && (cnt_q == CNT_LAST);
  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = dif_ext[MSB:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (dif_ext[MSB] != a[MSB]);
      end
      OP_NOT:  alu_res = ~a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SHL:  alu_res = a << b[SH_W-1:0];
      OP_SHR:  alu_res = a >> b[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b1;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;

      if (accept && is_mul) begin
        acc_q    <= '0;
        mcand_q  <= a;
        mplier_q <= b;
        cnt_q    <= '0;
      end else if (state_q == MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end

      // The product is registered on the final iteration; DONE keeps in_ready low one more cycle.
      if (accept && !is_mul) begin
        result    <= alu_res;
        carry     <= alu_c;
        ovf       <= alu_v;
        zero      <= (alu_res == '0);
        out_valid <= 1'b1;
      end else if (mul_last) begin
        result    <= acc_next;
        carry     <= 1'b0;
        ovf       <= 1'b0;
        zero      <= (acc_next == '0);
        out_valid <= 1'b1;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed self-checking bench for alu_pipe
module tb_alu_pipe;
  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic         carry, ovf, zero;
  logic [3:0]   op;
  logic [W-1:0] a, b, result;

  typedef struct { int res; int c; int v; int z; } exp_t;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   m_ov;
  int   m_busy;

  alu_pipe #(.WIDTH(W), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_alu(input int o, input int x, input int y);
    exp_t e;
    int sx, sy, r;
    sx = (x >= M / 2) ? x - M : x;
    sy = (y >= M / 2) ? y - M : y;
    e.c = 0;
    e.v = 0;
    case (o)
      0: begin r = x + y; e.c = int'(r >= M);
               e.v = int'((sx + sy > M / 2 - 1) || (sx + sy < -M / 2)); end
      1: begin r = x - y; e.c = int'(x >= y);
               e.v = int'((sx - sy > M / 2 - 1) || (sx - sy < -M / 2)); end
      2:  r = ~x;
      3:  r = x & y;
      4:  r = x | y;
      5:  r = x ^ y;
      6:  r = int'(sx < sy);
      7:  r = int'(x == y);
      8:  r = int'(x < y);
      9:  r = x << (y % W);
      10: r = x >> (y % W);
      11: r = x * y;
      default: r = 0;
    endcase
    e.res = r & (M - 1);
    e.z   = int'(e.res == 0);
    return e;
  endfunction

  // One clock cycle: inputs were set at the preceding negedge; check, then advance the model.
  task automatic cycle();
    exp_t e;
    bit   rdy, acc;
    #1;
    chk("out_valid", out_valid, m_ov);
    rdy = (m_busy == 0) && (!m_ov || out_ready);
    chk("in_ready", in_ready, rdy);
    if (m_ov && out_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("carry", carry, e.c);
        chk("ovf", ovf, e.v);
        chk("zero", zero, e.z);
      end
    end
    acc = in_valid && rdy;
    if (m_ov && out_ready) m_ov = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 1) m_ov = 1'b1;
    end else if (acc) begin
      sb.push_back(ref_alu(int'(op), int'(a), int'(b)));
      if (op == 4'd11) m_busy = W + 1;
      else m_ov = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_result", result, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 1);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_ov   = 1'b0;
    m_busy = 0;
    sb.delete();
  endtask

  task automatic directed(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int er, input int ec, input int ev,
                          input int ez, input int lat);
    int n;
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      cycle();
      n++;
    end
    chk({tag, "_lat"}, n + 1, lat);
    chk({tag, "_res"}, result, er);
    chk({tag, "_c"}, carry, ec);
    chk({tag, "_v"}, ovf, ev);
    chk({tag, "_z"}, zero, ez);
    cycle();
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    m_ov = 1'b0; m_busy = 0;
    do_reset();

    directed("add", 4'd0, 4'd7, 4'd1, 8, 0, 1, 0, 1);
    directed("sub_neg", 4'd1, 4'd3, 4'd5, 14, 0, 0, 0, 1);
    directed("sub_eq", 4'd1, 4'd5, 4'd5, 0, 1, 0, 1, 1);
    directed("slt", 4'd6, 4'hF, 4'd1, 1, 0, 0, 0, 1);
    directed("sltu", 4'd8, 4'hF, 4'd1, 0, 0, 0, 1, 1);
    directed("eq", 4'd7, 4'd9, 4'd9, 1, 0, 0, 0, 1);
    directed("shl", 4'd9, 4'd3, 4'd5, 6, 0, 0, 0, 1);
    directed("shr", 4'd10, 4'd8, 4'd6, 2, 0, 0, 0, 1);
    directed("rsvd", 4'd13, 4'hF, 4'hF, 0, 0, 0, 1, 1);
    directed("mul", 4'd11, 4'd3, 4'd5, 15, 0, 0, 0, W + 1);

    // Consumer stalls three cycles, then retire and accept coincide.
    in_valid = 1'b1; op = 4'd0; a = 4'd2; b = 4'd3; out_ready = 1'b1;
    cycle();
    a = 4'd1; b = 4'd1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_result", result, 5);
    end
    out_ready = 1'b1;
    cycle();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_result", result, 2);
    in_valid = 1'b0;
    cycle();

    // Reset during the second multiply cycle must abort without issuing a result.
    in_valid = 1'b1; op = 4'd11; a = 4'd3; b = 4'd5; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    do_reset();
    for (int i = 0; i < 8; i++) cycle();
    directed("post_rst", 4'd0, 4'd4, 4'd5, 9, 0, 1, 0, 1);

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 4'($urandom_range(0, 15));
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || m_busy != 0); i++) cycle();
    chk("drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
